mem_stage: RTL and testbench

- Pipeline MEM stage. Sits directly downstream of the EX stage and consumes its 139-bit EX_MEM register.
- Performs the data-memory access over a req/ack bus and selects the write-back value.
- Drives the MEM_WB pipeline register and the EX/MEM forwarding taps.
- Stalls upstream while a slow memory access is outstanding; aborts on timeout and raises a sticky bus error.

---
 rtl/mem_stage.sv | 120 ++++++++++++
 tb/tb_mem_stage.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory access over a req/ack bus, write-back select,
// MEM_WB register, EX/MEM forwarding taps, and timeout abort with a sticky bus error.
module mem_stage #(
  parameter int          TIMEOUT        = 16,
  parameter logic [31:0] ERR_LOAD_VALUE = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset_b,
  input  logic [138:0] EX_MEM,
  output logic         stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_ack,
  input  logic         err_clr,
  output logic         bus_err,
  output logic [4:0]   EX_MEM_Rd,
  output logic         EX_MEM_RegWrite,
  output logic [31:0]  EX_MEM_RdData,
  output logic [37:0]  MEM_WB
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;

  logic [31:0] st_data, alu_res, pc4, lu_data, load_data, wb_data;
  logic [4:0]  rd;
  logic        mem_read, mem_write, reg_write, lu_op, memop;
  logic [1:0]  mem_to_reg;
  logic        at_limit, abort;

  assign st_data    = EX_MEM[31:0];
  assign alu_res    = EX_MEM[63:32];
  assign rd         = EX_MEM[68:64];
  assign mem_read   = EX_MEM[69];
  assign mem_write  = EX_MEM[70];
  assign reg_write  = EX_MEM[71];
  assign mem_to_reg = EX_MEM[73:72];
  assign pc4        = EX_MEM[105:74];
  assign lu_data    = EX_MEM[137:106];
  assign lu_op      = EX_MEM[138];
  assign memop      = mem_read | mem_write;

  function automatic logic [31:0] wb_select(input logic [1:0]  sel,
                                            input logic        luop,
                                            input logic [31:0] lud,
                                            input logic [31:0] alu,
                                            input logic [31:0] ld,
                                            input logic [31:0] pcp4);
    case (sel)
      2'b00:   wb_select = luop ? lud : alu;
      2'b01:   wb_select = ld;
      2'b10:   wb_select = pcp4;
      default: wb_select = 32'h0;
    endcase
  endfunction

  // wait_cnt holds the number of request cycles already spent, so the current
  // cycle is number wait_cnt+1; abort on the TIMEOUT-th request cycle.
  assign at_limit  = (state == IDLE) ? (TIMEOUT == 1) : (wait_cnt == 8'(TIMEOUT - 1));
  assign abort     = reset_b & memop & ~mem_ack & at_limit;
  assign stall     = reset_b & memop & ~mem_ack & ~abort;
  assign mem_req   = reset_b & memop;
  assign mem_we    = mem_write;
  assign mem_addr  = {alu_res[31:2], 2'b00};
  assign mem_wdata = st_data;

  assign load_data = mem_ack ? mem_rdata : ERR_LOAD_VALUE;
  assign wb_data   = wb_select(mem_to_reg, lu_op, lu_data, alu_res, load_data, pc4);

  assign EX_MEM_Rd       = rd;
  assign EX_MEM_RegWrite = reg_write & ~mem_read;
  assign EX_MEM_RdData   = wb_select(mem_to_reg, lu_op, lu_data, alu_res, 32'h0, pc4);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      MEM_WB   <= '0;
      bus_err  <= 1'b0;
    end else begin
      // Stall cycles push a bubble so write-back sees the instruction only once.
      if (stall)
        MEM_WB <= '0;
      else
        MEM_WB <= {reg_write & (rd != 5'd0), rd, wb_data};

      if (abort)
        bus_err <= 1'b1;
      else if (err_clr)
        bus_err <= 1'b0;

      case (state)
        IDLE: begin
          if (stall) begin
            state    <= WAIT;
            wait_cnt <= 8'd1;
          end
        end
        WAIT: begin
          if (!stall) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: the bench plays upstream stage and memory, and
// predicts every cycle from a transaction-level model of the stage.
module tb_mem_stage;
  localparam int          TO   = 16;
  localparam logic [31:0] ERRV = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         reset_b;
  logic [138:0] EX_MEM;
  logic         stall, mem_req, mem_we;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic         mem_ack, err_clr, bus_err;
  logic [4:0]   EX_MEM_Rd;
  logic         EX_MEM_RegWrite;
  logic [31:0]  EX_MEM_RdData;
  logic [37:0]  MEM_WB;

  mem_stage #(.TIMEOUT(TO), .ERR_LOAD_VALUE(ERRV)) dut (
    .clk(clk), .reset_b(reset_b), .EX_MEM(EX_MEM), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err_clr(err_clr), .bus_err(bus_err),
    .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .EX_MEM_RdData(EX_MEM_RdData), .MEM_WB(MEM_WB)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  logic exp_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [138:0] make_ex(input logic [31:0] wd, input logic [31:0] alu,
                                           input logic [4:0] rd, input logic mr, input logic mw,
                                           input logic rw, input logic [1:0] m2r,
                                           input logic [31:0] pc4, input logic [31:0] lud,
                                           input logic luop);
    make_ex = {luop, lud, pc4, m2r, rw, mw, mr, rd, alu, wd};
  endfunction

  // One instruction through the stage; lat = cycles before ack (>= TO means never).
  task automatic run_instr(input logic [138:0] ex, input int lat,
                           input logic [31:0] rdata, input logic clr);
    logic [31:0] wd, alu, pc4, lud, val, fwd;
    logic [4:0]  rd;
    logic        mr, mw, rw, luop, memop, timed_out;
    logic [1:0]  m2r;
    logic [37:0] exp_wb;
    int          n;
    wd = ex[31:0]; alu = ex[63:32]; rd = ex[68:64]; mr = ex[69]; mw = ex[70];
    rw = ex[71]; m2r = ex[73:72]; pc4 = ex[105:74]; lud = ex[137:106]; luop = ex[138];
    memop     = mr | mw;
    timed_out = memop && (lat >= TO);
    n         = !memop ? 1 : (timed_out ? TO : lat + 1);
    case (m2r)
      2'b00:   val = luop ? lud : alu;
      2'b01:   val = timed_out ? ERRV : rdata;
      2'b10:   val = pc4;
      default: val = 32'h0;
    endcase
    fwd    = (m2r == 2'b00) ? (luop ? lud : alu) : (m2r == 2'b10) ? pc4 : 32'h0;
    exp_wb = {rw && (rd != 5'd0), rd, val};
    for (int c = 1; c <= n; c++) begin
      EX_MEM    = ex;
      mem_ack   = memop && (c == lat + 1);
      mem_rdata = mem_ack ? rdata : $urandom;
      err_clr   = clr;
      @(negedge clk);
      chk("stall", stall, (c < n));
      chk("mem_req", mem_req, memop);
      if (memop) begin
        chk("mem_addr", mem_addr, {alu[31:2], 2'b00});
        chk("mem_we", mem_we, mw);
        chk("mem_wdata", mem_wdata, wd);
      end
      chk("fwd_rd", EX_MEM_Rd, rd);
      chk("fwd_rw", EX_MEM_RegWrite, rw & ~mr);
      if (m2r != 2'b01) chk("fwd_data", EX_MEM_RdData, fwd);
      @(posedge clk); #1;
      if (timed_out && c == n) exp_err = 1'b1;
      else if (clr)            exp_err = 1'b0;
      chk("mem_wb", MEM_WB, (c < n) ? 38'h0 : exp_wb);
      chk("bus_err", bus_err, exp_err);
    end
    mem_ack = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic random_instr();
    logic [138:0] ex;
    int kind, lat;
    logic [1:0] m2r;
    kind = $urandom_range(0, 3);
    lat  = ($urandom_range(0, 5) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(0, 3);
    m2r  = 2'($urandom_range(0, 2));
    if (m2r == 2'b01) m2r = 2'b11;
    case (kind)
      0: ex = make_ex($urandom, $urandom, 5'($urandom), 0, 0, 1'($urandom), m2r,
                      $urandom, $urandom, 1'($urandom));
      1: ex = make_ex($urandom, $urandom, 5'($urandom), 1, 0, 1, 2'b01,
                      $urandom, $urandom, 1'($urandom));
      2: ex = make_ex($urandom, $urandom, 5'($urandom), 0, 1, 0, 2'b00,
                      $urandom, $urandom, 1'($urandom));
      default: ex = make_ex($urandom, $urandom, 5'($urandom), 1, 1, 0, 2'b00,
                            $urandom, $urandom, 1'($urandom));
    endcase
    run_instr(ex, lat, $urandom, ($urandom_range(0, 7) == 0));
  endtask

  initial begin
    reset_b = 1'b0; EX_MEM = '0; mem_rdata = '0; mem_ack = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_wb", MEM_WB, 38'h0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    reset_b = 1'b1;

    run_instr(make_ex(0, 32'h1234, 5, 0, 0, 1, 2'b00, 0, 32'hFFFF_0000, 0), 0, 0, 0);
    run_instr(make_ex(0, 32'h40, 7, 1, 0, 1, 2'b01, 0, 0, 0), 0, 32'hDEADBEEF, 0);
    run_instr(make_ex(32'hCAFE_F00D, 32'h83, 0, 0, 1, 0, 2'b00, 0, 0, 0), 3, 0, 0);
    run_instr(make_ex(0, 32'h100, 9, 1, 0, 1, 2'b01, 0, 0, 0), 100, 32'h5555_5555, 0);
    run_instr(make_ex(0, 32'h1, 3, 0, 0, 1, 2'b00, 0, 0, 0), 0, 0, 1);
    run_instr(make_ex(0, 0, 31, 0, 0, 1, 2'b10, 32'h0040_0008, 0, 0), 0, 0, 0);
    run_instr(make_ex(0, 0, 0, 0, 0, 1, 2'b10, 32'h0040_0008, 0, 0), 0, 0, 0);
    run_instr(make_ex(0, 32'h200, 4, 1, 0, 1, 2'b01, 0, 0, 0), TO - 1, 32'h0BAD_CAFE, 0);
    run_instr(make_ex(0, 32'h300, 6, 1, 0, 1, 2'b01, 0, 0, 0), TO, 32'h1111_1111, 0);

    // Abandon a waiting load by reset, then confirm a clean restart.
    EX_MEM  = make_ex(0, 32'h44, 8, 1, 0, 1, 2'b01, 0, 0, 0);
    mem_ack = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_b = 1'b0;
    #1;
    chk("rst_wait_req", mem_req, 1'b0);
    chk("rst_wait_wb", MEM_WB, 38'h0);
    chk("rst_wait_err", bus_err, 1'b0);
    exp_err = 1'b0;
    @(posedge clk); #1;
    reset_b = 1'b1;
    run_instr(make_ex(0, 32'h48, 10, 1, 0, 1, 2'b01, 0, 0, 0), 2, 32'h7777_8888, 0);

    repeat (200) random_instr();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
